// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised 2-read/1-write register file with a per-register busy scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] RA,
    input  logic [ADDR_WIDTH-1:0] RB,
    input  logic                  sig_enable_read,
    output logic [DATA_WIDTH-1:0] BusA,
    output logic [DATA_WIDTH-1:0] BusB,
    input  logic [ADDR_WIDTH-1:0] RW,
    input  logic [DATA_WIDTH-1:0] BusW,
    input  logic                  sig_enable_write,
    input  logic [ADDR_WIDTH-1:0] RD,
    input  logic                  sig_reserve,
    output logic                  busy_A,
    output logic                  busy_B,
    output logic                  sig_hazard
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic                  wr_ok;
    logic                  rsv_ok;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    // Register 0 is read-only and never reserved when it is hardwired to zero
    assign wr_ok  = sig_enable_write && !(ZERO_REG && RW == '0);
    assign rsv_ok = sig_reserve && !(ZERO_REG && RD == '0);

`ifdef REGFILE_BYPASS_EN
    // A same-cycle write retires the pending producer unless a new one is reserved alongside it
    assign busy_A = busy[RA] && !(wr_ok && RW == RA && !(rsv_ok && RD == RA));
    assign busy_B = busy[RB] && !(wr_ok && RW == RB && !(rsv_ok && RD == RB));
    assign rd_a   = (wr_ok && RW == RA) ? BusW : (ZERO_REG && RA == '0) ? '0 : regs[RA];
    assign rd_b   = (wr_ok && RW == RB) ? BusW : (ZERO_REG && RB == '0) ? '0 : regs[RB];
`else
    assign busy_A = busy[RA];
    assign busy_B = busy[RB];
    assign rd_a   = (ZERO_REG && RA == '0) ? '0 : regs[RA];
    assign rd_b   = (ZERO_REG && RB == '0) ? '0 : regs[RB];
`endif

    assign sig_hazard = sig_enable_read && (busy_A || busy_B);

    // Storage array: writeback updates one register per edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[RW] <= BusW;
        end
    end

    // Scoreboard: write clears, reserve sets; reserve is applied last so it wins a collision
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            if (wr_ok) busy[RW] <= 1'b0;
            if (rsv_ok) busy[RD] <= 1'b1;
        end
    end

    // Read ports capture only when no operand is pending, otherwise they hold for the retry
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            BusA <= '0;
            BusB <= '0;
        end else if (sig_enable_read && !sig_hazard) begin
            BusA <= rd_a;
            BusB <= rd_b;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed table, corner sequences and random traffic against a reference model.
module tb_regfile_scoreboard;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  RA = '0, RB = '0, RW = '0, RD = '0;
    logic [15:0] BusW = '0;
    logic        sig_enable_read = 1'b0, sig_enable_write = 1'b0, sig_reserve = 1'b0;
    logic [15:0] BusA, BusB;
    logic        busy_A, busy_B, sig_hazard;

    logic [3:0]  c_ra = '0, c_rb = '0, c_rw = '0, c_rd = '0;
    logic [31:0] c_bw = '0;
    logic        c_re = 1'b0, c_we = 1'b0, c_rs = 1'b0;
    logic [31:0] c_ba, c_bb;
    logic        c_busy_a, c_busy_b, c_haz;

    int checks = 0;
    int errors = 0;

    logic [15:0] mreg [8];
    logic        mbusy [8];
    logic [15:0] ma, mb;

    typedef struct {
        logic [2:0]  ra, rb;
        logic        re;
        logic [2:0]  rw;
        logic [15:0] bw;
        logic        we;
        logic [2:0]  rd;
        logic        rs;
        logic        ea, eb, eh;
        logic [15:0] eba, ebb;
    } vec_t;
    vec_t tbl [13];

    always #5 clock = ~clock;

    regfile_scoreboard dut (
        .clock(clock), .reset_n(reset_n), .RA(RA), .RB(RB), .sig_enable_read(sig_enable_read),
        .BusA(BusA), .BusB(BusB), .RW(RW), .BusW(BusW), .sig_enable_write(sig_enable_write),
        .RD(RD), .sig_reserve(sig_reserve), .busy_A(busy_A), .busy_B(busy_B), .sig_hazard(sig_hazard)
    );

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .ZERO_REG(1'b0)) dut_wide (
        .clock(clock), .reset_n(reset_n), .RA(c_ra), .RB(c_rb), .sig_enable_read(c_re),
        .BusA(c_ba), .BusB(c_bb), .RW(c_rw), .BusW(c_bw), .sig_enable_write(c_we),
        .RD(c_rd), .sig_reserve(c_rs), .busy_A(c_busy_a), .busy_B(c_busy_b), .sig_hazard(c_haz)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mreg[i] = '0;
            mbusy[i] = 1'b0;
        end
        ma = '0;
        mb = '0;
    endtask

    function automatic logic [15:0] rv(input logic [2:0] a, input logic [2:0] rw, input logic [15:0] bw, input logic we);
`ifdef REGFILE_BYPASS_EN
        if (we && rw != 0 && rw == a) return bw;
`endif
        return (a == 0) ? 16'h0 : mreg[a];
    endfunction

    function automatic logic mb_eff(input logic [2:0] a, input logic [2:0] rw, input logic we, input logic [2:0] rd, input logic rs);
`ifdef REGFILE_BYPASS_EN
        if (we && rw != 0 && rw == a && !(rs && rd != 0 && rd == a)) return 1'b0;
`endif
        return mbusy[a];
    endfunction

    // One cycle starting at a falling edge: drive, check combinational outputs, clock, check read buses.
    task automatic cyc(input logic [2:0] ra, input logic [2:0] rb, input logic re,
                       input logic [2:0] rw, input logic [15:0] bw, input logic we,
                       input logic [2:0] rd, input logic rs,
                       output logic ga, output logic gb, output logic gh,
                       output logic [15:0] gba, output logic [15:0] gbb);
        logic ea, eb, eh;
        RA = ra; RB = rb; sig_enable_read = re; RW = rw; BusW = bw;
        sig_enable_write = we; RD = rd; sig_reserve = rs;
        #1;
        ea = mb_eff(ra, rw, we, rd, rs);
        eb = mb_eff(rb, rw, we, rd, rs);
        eh = re && (ea || eb);
        ga = busy_A; gb = busy_B; gh = sig_hazard;
        chk("busy_A", {31'b0, busy_A}, {31'b0, ea});
        chk("busy_B", {31'b0, busy_B}, {31'b0, eb});
        chk("sig_hazard", {31'b0, sig_hazard}, {31'b0, eh});
        @(posedge clock);
        if (re && !eh) begin
            ma = rv(ra, rw, bw, we);
            mb = rv(rb, rw, bw, we);
        end
        if (we && rw != 0) begin
            mreg[rw] = bw;
            mbusy[rw] = 1'b0;
        end
        if (rs && rd != 0) mbusy[rd] = 1'b1;
        @(negedge clock);
        gba = BusA; gbb = BusB;
        chk("BusA", {16'b0, BusA}, {16'b0, ma});
        chk("BusB", {16'b0, BusB}, {16'b0, mb});
    endtask

    initial begin
        logic ga, gb, gh;
        logic [15:0] gba, gbb;
        tbl[0]  = '{3'd0, 3'd0, 1'b0, 3'd3, 16'hBEEF, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[1]  = '{3'd3, 3'd0, 1'b1, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h0000};
        tbl[2]  = '{3'd0, 3'd0, 1'b0, 3'd0, 16'h1234, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'h0000};
        tbl[3]  = '{3'd0, 3'd3, 1'b1, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hBEEF};
        tbl[4]  = '{3'd0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hBEEF};
        tbl[5]  = '{3'd2, 3'd3, 1'b1, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'hBEEF};
        tbl[6]  = '{3'd0, 3'd0, 1'b0, 3'd2, 16'h00AA, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hBEEF};
        tbl[7]  = '{3'd2, 3'd3, 1'b1, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00AA, 16'hBEEF};
        tbl[8]  = '{3'd0, 3'd0, 1'b0, 3'd4, 16'h5555, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00AA, 16'hBEEF};
        tbl[9]  = '{3'd4, 3'd2, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00AA, 16'hBEEF};
        tbl[10] = '{3'd4, 3'd2, 1'b1, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00AA, 16'hBEEF};
        tbl[11] = '{3'd0, 3'd0, 1'b0, 3'd4, 16'h7777, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00AA, 16'hBEEF};
        tbl[12] = '{3'd4, 3'd2, 1'b1, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7777, 16'h00AA};
        model_reset();
        #12;
        chk("reset BusA", {16'b0, BusA}, 32'h0);
        chk("reset BusB", {16'b0, BusB}, 32'h0);
        chk("reset busy_A", {31'b0, busy_A}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].ra, tbl[i].rb, tbl[i].re, tbl[i].rw, tbl[i].bw, tbl[i].we, tbl[i].rd, tbl[i].rs, ga, gb, gh, gba, gbb);
            chk($sformatf("tbl%0d busy_A", i), {31'b0, ga}, {31'b0, tbl[i].ea});
            chk($sformatf("tbl%0d busy_B", i), {31'b0, gb}, {31'b0, tbl[i].eb});
            chk($sformatf("tbl%0d hazard", i), {31'b0, gh}, {31'b0, tbl[i].eh});
            chk($sformatf("tbl%0d BusA", i), {16'b0, gba}, {16'b0, tbl[i].eba});
            chk($sformatf("tbl%0d BusB", i), {16'b0, gbb}, {16'b0, tbl[i].ebb});
        end

        cyc(3'd0, 3'd0, 1'b0, 3'd6, 16'h1111, 1'b1, 3'd0, 1'b0, ga, gb, gh, gba, gbb);
        cyc(3'd6, 3'd0, 1'b1, 3'd6, 16'h2222, 1'b1, 3'd0, 1'b0, ga, gb, gh, gba, gbb);
`ifdef REGFILE_BYPASS_EN
        chk("r6 same-cycle BusA", {16'b0, gba}, 32'h2222);
`else
        chk("r6 same-cycle BusA", {16'b0, gba}, 32'h1111);
`endif
        cyc(3'd0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd6, 1'b1, ga, gb, gh, gba, gbb);
        cyc(3'd6, 3'd0, 1'b1, 3'd6, 16'h3333, 1'b1, 3'd0, 1'b0, ga, gb, gh, gba, gbb);
`ifdef REGFILE_BYPASS_EN
        chk("r6 busy bypass hazard", {31'b0, gh}, 32'h0);
        chk("r6 busy bypass BusA", {16'b0, gba}, 32'h3333);
`else
        chk("r6 busy hazard", {31'b0, gh}, 32'h1);
        chk("r6 busy hold BusA", {16'b0, gba}, 32'h1111);
`endif

        cyc(3'd0, 3'd0, 1'b0, 3'd5, 16'hABCD, 1'b1, 3'd1, 1'b1, ga, gb, gh, gba, gbb);
        cyc(3'd5, 3'd5, 1'b1, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, ga, gb, gh, gba, gbb);
        chk("pre-reset r5", {16'b0, gba}, 32'hABCD);
        RA = 3'd1; RB = 3'd5; sig_enable_read = 1'b0;
        #1;
        chk("pre-reset busy r1", {31'b0, busy_A}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset BusA", {16'b0, BusA}, 32'h0);
        chk("async reset BusB", {16'b0, BusB}, 32'h0);
        chk("async reset busy_A", {31'b0, busy_A}, 32'h0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        cyc(3'd5, 3'd1, 1'b1, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0, ga, gb, gh, gba, gbb);
        chk("post-reset r5", {16'b0, gba}, 32'h0);

        c_rw = 4'd15; c_bw = 32'hDEADBEEF; c_we = 1'b1;
        @(negedge clock);
        c_rw = 4'd0; c_bw = 32'hCAFE0001;
        @(negedge clock);
        c_we = 1'b0; c_ra = 4'd15; c_rb = 4'd0; c_re = 1'b1;
        #1;
        chk("wide hazard", {31'b0, c_haz}, 32'h0);
        @(negedge clock);
        c_re = 1'b0;
        chk("wide r15", c_ba, 32'hDEADBEEF);
        chk("wide r0", c_bb, 32'hCAFE0001);

        for (int n = 0; n < 1500; n++) begin
            cyc(3'($urandom), 3'($urandom), 1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
                $urandom_range(0, 9) < 6, 3'($urandom), $urandom_range(0, 9) < 2, ga, gb, gh, gba, gbb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
